// File: rtl/pin_bank_if.sv
// pin_bank_if: register port and pad-side signals of the pin_bank controller.
// The master side is the top level / software; the pin_bank sits on the slave side.
interface pin_bank_if #(
    parameter int unsigned NPINS  = 12,
    parameter int unsigned DUTY_W = 8
);
    logic                WE;
    logic [3:0]          WADDR;
    logic [DUTY_W+1:0]   WDATA;
    logic [3:0]          RADDR;
    logic [DUTY_W+2:0]   RDATA;
    logic [NPINS-1:0]    PIN_IN;
    logic [NPINS-1:0]    PIN_OUT;
    logic [NPINS-1:0]    PIN_OE;
    logic                LEDn;

    modport master (
        output WE, WADDR, WDATA, RADDR, PIN_IN,
        input  RDATA, PIN_OUT, PIN_OE, LEDn
    );

    modport slave (
        input  WE, WADDR, WDATA, RADDR, PIN_IN,
        output RDATA, PIN_OUT, PIN_OE, LEDn
    );
endinterface

// File: rtl/pin_bank.sv
// pin_bank: NPINS independently configurable pad channels (low / high / hi-Z / PWM)
// with a double-buffered PWM duty per channel, synchronised pad inputs and a
// registered readback port.
// Optional feature: define PIN_BANK_HEARTBEAT_EN to make LEDn toggle on every
// PWM wrap; otherwise LEDn is tied low (LED on as a power indicator).
module pin_bank #(
    parameter int unsigned NPINS    = 12,
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned PRESCALE = 8
) (
    input logic       INTERNAL_OSC,
    input logic       RST,
    pin_bank_if.slave bus
);
    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned RdW = DUTY_W + 3;

    logic [PsW-1:0]    ps_q;
    logic [DUTY_W-1:0] pwm_cnt_q;
    logic              tick;
    logic              wrap;

    logic [1:0]        mode_q   [NPINS];
    logic [DUTY_W-1:0] shadow_q [NPINS];
    logic [DUTY_W-1:0] active_q [NPINS];

    logic [NPINS-1:0]  sync1_q;
    logic [NPINS-1:0]  sync2_q;
    logic [NPINS-1:0]  pin_oe_q;
    logic [NPINS-1:0]  pin_out_q;
    logic [RdW-1:0]    rdata_d;
    logic [RdW-1:0]    rdata_q;

    assign tick = (ps_q == PsW'(PRESCALE - 1));
    assign wrap = tick && (pwm_cnt_q == '1);

    // Prescaler divides the oscillator down to one PWM step per tick
    always_ff @(posedge INTERNAL_OSC) begin
        if (RST) begin
            ps_q      <= '0;
            pwm_cnt_q <= '0;
        end else if (tick) begin
            ps_q      <= '0;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end else begin
            ps_q      <= ps_q + 1'b1;
        end
    end

    // Channel configuration; the active duty only moves at a period boundary so
    // a same-cycle write lands in the shadow and waits one more period
    always_ff @(posedge INTERNAL_OSC) begin
        for (int i = 0; i < NPINS; i++) begin
            if (RST) begin
                mode_q[i]   <= 2'd0;
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end else begin
                if (wrap) begin
                    active_q[i] <= shadow_q[i];
                end
                // Addresses at or above NPINS match no channel and are dropped
                if (bus.WE && (bus.WADDR == 4'(i))) begin
                    mode_q[i]   <= bus.WDATA[DUTY_W +: 2];
                    shadow_q[i] <= bus.WDATA[DUTY_W-1:0];
                end
            end
        end
    end

    // Two-flop synchroniser on the raw pad inputs
    always_ff @(posedge INTERNAL_OSC) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.PIN_IN;
            sync2_q <= sync1_q;
        end
    end

    // Registered pad drivers decoded from each channel's mode
    always_ff @(posedge INTERNAL_OSC) begin
        for (int i = 0; i < NPINS; i++) begin
            if (RST) begin
                pin_oe_q[i]  <= 1'b1;
                pin_out_q[i] <= 1'b0;
            end else begin
                case (mode_q[i])
                    2'd0: begin
                        pin_oe_q[i]  <= 1'b1;
                        pin_out_q[i] <= 1'b0;
                    end
                    2'd1: begin
                        pin_oe_q[i]  <= 1'b1;
                        pin_out_q[i] <= 1'b1;
                    end
                    2'd2: begin
                        pin_oe_q[i]  <= 1'b0;
                        pin_out_q[i] <= 1'b0;
                    end
                    default: begin
                        pin_oe_q[i]  <= 1'b1;
                        pin_out_q[i] <= (pwm_cnt_q < active_q[i]);
                    end
                endcase
            end
        end
    end

    // Readback mux; out-of-range channels read as zero
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NPINS; i++) begin
            if (bus.RADDR == 4'(i)) begin
                rdata_d = {sync2_q[i], mode_q[i], shadow_q[i]};
            end
        end
    end

    // Readback register
    always_ff @(posedge INTERNAL_OSC) begin
        if (RST) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign bus.PIN_OE  = pin_oe_q;
    assign bus.PIN_OUT = pin_out_q;
    assign bus.RDATA   = rdata_q;

`ifdef PIN_BANK_HEARTBEAT_EN
    logic led_q;

    // Heartbeat flips once per PWM period
    always_ff @(posedge INTERNAL_OSC) begin
        if (RST) begin
            led_q <= 1'b0;
        end else if (wrap) begin
            led_q <= ~led_q;
        end
    end

    assign bus.LEDn = led_q;
`else
    assign bus.LEDn = 1'b0;
`endif

endmodule

// File: tb/tb_pin_bank.sv
// tb_pin_bank: randomized stimulus against a cycle-indexed reference model.
// Expected outputs are queued at every clock edge and checked by a separate
// monitor on the falling edge; directed checks cover the PWM duty counts,
// wrap-cycle writes, input latency and mid-period reset.
module tb_pin_bank;
    localparam int unsigned NPINS    = 12;
    localparam int unsigned DUTY_W   = 8;
    localparam int unsigned PRESCALE = 8;
    localparam int unsigned STEPS    = 1 << DUTY_W;
    localparam int unsigned PERIOD   = PRESCALE * STEPS;
`ifdef PIN_BANK_HEARTBEAT_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    pin_bank_if #(.NPINS(NPINS), .DUTY_W(DUTY_W)) bus ();

    pin_bank #(
        .NPINS   (NPINS),
        .DUTY_W  (DUTY_W),
        .PRESCALE(PRESCALE)
    ) dut (
        .INTERNAL_OSC(clk),
        .RST         (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NPINS-1:0]  oe;
        logic [NPINS-1:0]  out;
        logic [DUTY_W+2:0] rd;
        logic              led;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state, indexed by cycles since the last reset edge
    int               m_mode   [NPINS];
    int               m_shadow [NPINS];
    int               m_active [NPINS];
    logic [NPINS-1:0] m_s1, m_s2;
    logic             m_led;
    int               cyc;
    bit               model_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Model: predict the state after this edge from the state before it
    always @(posedge clk) begin
        exp_t e;
        int   step;
        int   r;
        bit   wrap;
        if (rst) begin
            for (int i = 0; i < NPINS; i++) begin
                m_mode[i]   = 0;
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            m_s1 = '0;
            m_s2 = '0;
            m_led = 1'b0;
            cyc = 0;
            model_on = 1'b1;
            e.oe = '1;
            e.out = '0;
            e.rd = '0;
            e.led = 1'b0;
            sb_q.push_back(e);
        end else if (model_on) begin
            step = (cyc / PRESCALE) % STEPS;
            wrap = ((cyc % PERIOD) == PERIOD - 1);
            for (int i = 0; i < NPINS; i++) begin
                case (m_mode[i])
                    0: begin e.oe[i] = 1'b1; e.out[i] = 1'b0; end
                    1: begin e.oe[i] = 1'b1; e.out[i] = 1'b1; end
                    2: begin e.oe[i] = 1'b0; e.out[i] = 1'b0; end
                    default: begin e.oe[i] = 1'b1; e.out[i] = (step < m_active[i]); end
                endcase
            end
            r = int'(bus.RADDR);
            e.rd = '0;
            if (r < NPINS) e.rd = {m_s2[r], 2'(m_mode[r]), DUTY_W'(m_shadow[r])};
            if (HB && wrap) m_led = ~m_led;
            e.led = m_led;
            if (wrap) begin
                for (int i = 0; i < NPINS; i++) m_active[i] = m_shadow[i];
            end
            if (bus.WE && (int'(bus.WADDR) < NPINS)) begin
                m_mode[int'(bus.WADDR)]   = int'(bus.WDATA[DUTY_W +: 2]);
                m_shadow[int'(bus.WADDR)] = int'(bus.WDATA[DUTY_W-1:0]);
            end
            m_s2 = m_s1;
            m_s1 = bus.PIN_IN;
            cyc++;
            sb_q.push_back(e);
        end
    end

    // Monitor: compare every cycle against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_pin_oe", 32'(bus.PIN_OE), 32'(e.oe));
            check("sb_pin_out", 32'(bus.PIN_OUT), 32'(e.out));
            check("sb_rdata", 32'(bus.RDATA), 32'(e.rd));
            check("sb_ledn", 32'(bus.LEDn), 32'(e.led));
        end
    end

    // One cycle of background traffic; never touches channel 0
    task automatic idle_rand(input int n, input bit rnd);
        repeat (n) begin
            @(negedge clk);
            bus.WE = 1'b0;
            if (rnd) begin
                bus.RADDR = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) bus.PIN_IN = NPINS'($urandom);
                if ($urandom_range(0, 15) == 0) begin
                    bus.WE    = 1'b1;
                    bus.WADDR = 4'($urandom_range(1, 15));
                    bus.WDATA = (DUTY_W + 2)'($urandom);
                end
            end
        end
    endtask

    task automatic wr(input int a, input int m, input int d);
        @(negedge clk);
        bus.WE    = 1'b1;
        bus.WADDR = 4'(a);
        bus.WDATA = {2'(m), DUTY_W'(d)};
        @(negedge clk);
        bus.WE = 1'b0;
    endtask

    task automatic count_high(output int n);
        n = 0;
        repeat (PERIOD) begin
            idle_rand(1, 1'b1);
            n += int'(bus.PIN_OUT[0]);
        end
    endtask

    initial begin
        int n;
        bus.WE = 1'b0;
        bus.WADDR = '0;
        bus.WDATA = '0;
        bus.RADDR = '0;
        bus.PIN_IN = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state held through an idle stretch
        idle_rand(100, 1'b0);
        check("idle_oe", 32'(bus.PIN_OE), 32'hFFF);
        check("idle_out", 32'(bus.PIN_OUT), 32'h0);
        check("idle_led", 32'(bus.LEDn), 32'h0);
        check("idle_rdata", 32'(bus.RDATA), 32'h0);

        // Mode writes and one-cycle output lag
        wr(3, 2, 0);
        check("oe3_before", 32'(bus.PIN_OE[3]), 32'h1);
        @(negedge clk);
        check("oe3_hiz", 32'(bus.PIN_OE[3]), 32'h0);
        wr(5, 1, 0);
        check("out5_before", 32'(bus.PIN_OUT[5]), 32'h0);
        bus.RADDR = 4'd5;
        @(negedge clk);
        check("out5_high", 32'(bus.PIN_OUT[5]), 32'h1);
        check("rd5_mode1", 32'(bus.RDATA), 32'h100);

        // PWM duty 64 from the first wrap onward
        wr(0, 3, 64);
        while ((cyc % PERIOD) != 0) idle_rand(1, 1'b1);
        count_high(n);
        check("duty64_period", 32'(n), 32'd512);

        // Duty write landing on the wrap edge is deferred one period
        while ((cyc % PERIOD) != PERIOD - 1) idle_rand(1, 1'b1);
        bus.WE    = 1'b1;
        bus.WADDR = 4'd0;
        bus.WDATA = {2'd3, DUTY_W'(192)};
        count_high(n);
        check("wrapwr_old_duty", 32'(n), 32'd512);
        count_high(n);
        check("wrapwr_new_duty", 32'(n), 32'd1536);

        // Out-of-range write and readback
        @(negedge clk);
        bus.WE    = 1'b1;
        bus.WADDR = 4'd14;
        bus.WDATA = {2'd1, DUTY_W'(8'hA5)};
        bus.RADDR = 4'd14;
        @(negedge clk);
        bus.WE = 1'b0;
        @(negedge clk);
        check("rd14_zero", 32'(bus.RDATA), 32'h0);

        // Pad input to readback latency
        bus.PIN_IN = '0;
        bus.RADDR  = 4'd7;
        idle_rand(4, 1'b0);
        bus.PIN_IN[7] = 1'b1;
        @(negedge clk);
        check("pin7_lat1", 32'(bus.RDATA[DUTY_W+2]), 32'h0);
        @(negedge clk);
        check("pin7_lat2", 32'(bus.RDATA[DUTY_W+2]), 32'h0);
        @(negedge clk);
        check("pin7_lat3", 32'(bus.RDATA[DUTY_W+2]), 32'h1);

        // Reset mid-period with PWM running
        while ((cyc % PERIOD) != 1000) idle_rand(1, 1'b1);
        bus.WE = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_oe", 32'(bus.PIN_OE), 32'hFFF);
        check("rst_out", 32'(bus.PIN_OUT), 32'h0);
        check("rst_rdata", 32'(bus.RDATA), 32'h0);
        check("rst_led", 32'(bus.LEDn), 32'h0);

        // Heartbeat timing after reset
        while (cyc != PERIOD - 1) idle_rand(1, 1'b1);
        check("led_pre_wrap", 32'(bus.LEDn), 32'h0);
        idle_rand(1, 1'b1);
        check("led_wrap1", 32'(bus.LEDn), 32'(HB));
        while (cyc != 2 * PERIOD) idle_rand(1, 1'b1);
        check("led_wrap2", 32'(bus.LEDn), 32'h0);
        idle_rand(20, 1'b1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
